sequencer_track: RTL and testbench
==================================

// Module: sequencer_track
// PURPOSE
//  Next-generation single-voice sequencer track: a STEPS-deep note memory with one entry per step.
//  - Edit: per-step note editing with wrap-around note cycling.
//  - Playback: on beat strobes, reads the step selected by the measure counter.
//  - Output: a note code plus a gate with programmable length and a retrigger gap.
//  - Sits between the measure counter and the note-to-frequency/oscillator stage.
//  - One instance per track; stored notes are kept while the chip is in piano mode.
// PARAMETERS
//  STEPS      8   number of steps per measure (>=2); STEP_W = $clog2(STEPS)
//  NOTE_W     4   width of the note code
//  NUM_NOTES  13  highest note code; codes cycle 0(OFF),1..NUM_NOTES,0
//  GATE_W     4   width of the gate_len input and the gate counter
// PORTS
//  clk           in   1       system clock (10 kHz)
//  n_rst         in   1       asynchronous reset, active low
//  sequencer_on  in   1       1 = sequencer mode, 0 = piano mode
//  toggle        in   1       edge-detected pulse; advances the note at edit_step
//  edit_step     in   STEP_W  step being edited
//  clear         in   1       pulse; writes OFF into every step
//  beat          in   STEP_W  current step from the measure counter
//  beat_strobe   in   1       one-cycle pulse when beat changes
//  gate_len      in   GATE_W  gate length in cycles; 0 is treated as 1
//  note_out      out  NOTE_W  sounding note code; 0 when silent
//  gate          out  1       high while the note sounds
//  edit_note     out  NOTE_W  stored note at edit_step (combinational read, for display)
// BEHAVIOUR
//  Reset
//  - Async, n_rst=0: all memory = 0, note_out = 0, gate = 0, counter = 0, FSM = IDLE.
//  - Reset mid-gate aborts the gate immediately.
//  Edit (only when sequencer_on=1)
//  - toggle: mem[edit_step] <= (mem == NUM_NOTES) ? 0 : mem+1.
//  - edit_step >= STEPS: toggle is ignored.
//  - toggle when sequencer_on=0: ignored.
//  - clear: all steps <= 0 in one cycle. clear beats toggle in the same cycle.
//  Playback
//  - Ignored when sequencer_on=0.
//  - On beat_strobe at cycle N, n = mem[beat] (value before any same-cycle toggle write).
//  - beat >= STEPS reads as n = 0.
//  Gate FSM (all outputs registered; response appears from N+1)
//  - IDLE: gate=0, note_out=0.
//    - strobe with n!=0 -> ON: note_out=n, gate=1, cnt=max(gate_len,1)-1.
//  - ON: gate=1.
//    - cnt==0 and no strobe -> IDLE.
//    - otherwise cnt decrements.
//  - Strobe while ON:
//    - n==0 -> IDLE.
//    - n!=0 -> GAP: gate=0, note_out=n for exactly one cycle, then ON with a fresh count.
//  - GAP: if a strobe arrives during GAP, its n replaces the pending note. The gap stays one cycle.
//  - Strobe at the exact cycle cnt reaches 0 counts as "while ON" (retrigger gap applies).
//  - gate_len is sampled only when a note is launched; later changes affect the next note.
//  - sequencer_on 1->0: next cycle FSM = IDLE, outputs 0. Memory is retained.
//  - sequencer_on 0->1: no note sounds until the next beat_strobe.
// CONFIGURATION
//  SEQ_TRACK_TIE_EN defined:
//  - Strobe while ON (or at cnt==0 expiry) with n == note_out does not enter GAP.
//  - Gate stays high and the counter reloads at N+1 (legato tie).
//  - Different notes still take GAP.
//  SEQ_TRACK_TIE_EN undefined: every non-zero retrigger takes GAP. No tie logic is synthesised.
// TESTING
//  - Reset/edit: 14 toggles at edit_step=2 -> edit_note 1,2..13,0; other steps stay 0.
//    edit_step=STEPS (non-pow2 STEPS) or sequencer_on=0 -> memory unchanged.
//  - Single note: mem[3]=5, gate_len=3, strobe at N with beat=3 -> note_out=5,
//    gate=1 in N+1..N+3, gate=0 and note_out=0 at N+4. gate_len=0 -> gate high N+1 only.
//  - Retrigger: gate_len=8, mem[0]=5, mem[1]=7, strobes 4 cycles apart ->
//    gate 1,1,1,1,0 (GAP, note_out=7),1... With TIE_EN and mem[1]=5: no 0 cycle,
//    gate stays high 8 cycles past the 2nd strobe.
//  - Rest/off: strobe on step with note 0 while ON -> gate=0, note_out=0 next cycle.
//    sequencer_on drop mid-gate -> outputs 0 next cycle. Re-enable -> memory intact.
//  - Collisions: toggle on beat step in the same cycle as strobe -> old note plays, new value stored.
//    clear+toggle same cycle -> all steps 0.
//  - Reset mid-gate (n_rst low between clk edges) -> gate=0 and note_out=0 immediately.

Source files
------------

// File: rtl/sequencer_track.sv
// sequencer_track
//   Single-voice sequencer track. Holds a STEPS-deep note memory (one note code
//   per step), lets the user cycle the note of any step, and on every beat
//   strobe plays the note of the current step as a registered note code plus a
//   gate of programmable length. Back-to-back notes are separated by a
//   one-cycle retrigger gap so the oscillator stage sees a fresh attack.
//   Stored notes survive piano mode (sequencer_on = 0). Only reset or clear
//   erases them.
//
//   Build option:
//     SEQ_TRACK_TIE_EN  when defined, retriggering the note that is already
//                       sounding skips the gap. The gate stays high and the
//                       length counter reloads, which gives a legato tie.
//
//   Ports:
//     clk           system clock
//     n_rst         asynchronous reset, active low
//     sequencer_on  1 = sequencer mode, 0 = piano mode (track silent, no edits)
//     toggle        pulse: advance note at edit_step (0,1..NUM_NOTES,0,...)
//     edit_step     step being edited
//     clear         pulse: write OFF (0) into every step; wins over toggle
//     beat          current step from the measure counter
//     beat_strobe   one-cycle pulse when beat changes
//     gate_len      gate length in cycles (0 behaves as 1), sampled at launch
//     note_out      sounding note code, 0 when silent
//     gate          high while the note sounds
//     edit_note     stored note at edit_step (combinational, for display)
//
//   Gate FSM states:
//     state  | meaning
//     S_IDLE | silent, waiting for a strobe on a non-OFF step
//     S_ON   | gate high, cnt_q counts down the remaining gate cycles
//     S_GAP  | one-cycle retrigger gap, note_out already holds the next note

module sequencer_track #(
    parameter int STEPS     = 8,
    parameter int NOTE_W    = 4,
    parameter int NUM_NOTES = 13,
    parameter int GATE_W    = 4,
    localparam int STEP_W   = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sequencer_on,
    input  logic              toggle,
    input  logic [STEP_W-1:0] edit_step,
    input  logic              clear,
    input  logic [STEP_W-1:0] beat,
    input  logic              beat_strobe,
    input  logic [GATE_W-1:0] gate_len,
    output logic [NOTE_W-1:0] note_out,
    output logic              gate,
    output logic [NOTE_W-1:0] edit_note
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [STEP_W:0]   STEPS_C  = (STEP_W + 1)'(STEPS);
    localparam logic [NOTE_W-1:0] NOTE_MAX = NOTE_W'(NUM_NOTES);

    logic [NOTE_W-1:0] mem [STEPS];

    state_t            state_q, state_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              gate_q, gate_d;
    logic [GATE_W-1:0] cnt_q, cnt_d;

    logic              edit_in_range;
    logic              beat_in_range;
    logic [NOTE_W-1:0] edit_next;
    logic [NOTE_W-1:0] play_note;
    logic [GATE_W-1:0] cnt_reload;

    // Steps beyond STEPS only exist when STEPS is not a power of two. They
    // read back as OFF and are never written.
    assign edit_in_range = ({1'b0, edit_step} < STEPS_C);
    assign beat_in_range = ({1'b0, beat} < STEPS_C);

    assign edit_note = edit_in_range ? mem[edit_step] : '0;
    assign edit_next = (edit_note == NOTE_MAX) ? '0 : edit_note + NOTE_W'(1);

    // Read the step before any write in the same cycle, so a toggle on the
    // playing step lets the old note sound and the new value is stored.
    assign play_note = beat_in_range ? mem[beat] : '0;

    // The down-counter terminates at 0, so a length of L loads L-1. A length
    // of 0 is clamped so that it gives a single-cycle gate.
    assign cnt_reload = (gate_len == '0) ? '0 : gate_len - GATE_W'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < STEPS; i++) begin
                mem[i] <= '0;
            end
        end else if (sequencer_on) begin
            if (clear) begin
                for (int i = 0; i < STEPS; i++) begin
                    mem[i] <= '0;
                end
            end else if (toggle && edit_in_range) begin
                mem[edit_step] <= edit_next;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            note_q  <= '0;
            gate_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;

        if (!sequencer_on) begin
            state_d = S_IDLE;
            note_d  = '0;
            gate_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (beat_strobe && (play_note != '0)) begin
                        state_d = S_ON;
                        note_d  = play_note;
                        gate_d  = 1'b1;
                        cnt_d   = cnt_reload;
                    end
                end

                S_ON: begin
                    // A strobe takes priority over expiry, so a strobe that
                    // arrives on the last gate cycle still gets the gap.
                    if (beat_strobe) begin
                        if (play_note == '0) begin
                            state_d = S_IDLE;
                            note_d  = '0;
                            gate_d  = 1'b0;
                            cnt_d   = '0;
`ifdef SEQ_TRACK_TIE_EN
                        end else if (play_note == note_q) begin
                            cnt_d   = cnt_reload;
`endif
                        end else begin
                            state_d = S_GAP;
                            note_d  = play_note;
                            gate_d  = 1'b0;
                        end
                    end else if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        note_d  = '0;
                        gate_d  = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - GATE_W'(1);
                    end
                end

                S_GAP: begin
                    // The gap always lasts one cycle. A strobe that lands in
                    // the gap replaces the pending note, and a rest silences
                    // the track.
                    if (beat_strobe && (play_note == '0)) begin
                        state_d = S_IDLE;
                        note_d  = '0;
                        gate_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ON;
                        gate_d  = 1'b1;
                        cnt_d   = cnt_reload;
                        if (beat_strobe) begin
                            note_d = play_note;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    note_d  = '0;
                    gate_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign note_out = note_q;
    assign gate     = gate_q;

endmodule

// File: tb/tb_sequencer_track.sv
// tb_sequencer_track
//   Directed bench for sequencer_track. The track is built with six steps so
//   that an out-of-range step index can be exercised. Stimulus pushes one
//   expected {gate, note_out[, edit_note]} record per clock. A monitor pops
//   each record one clock later, after the edge that consumed the stimulus,
//   and compares it.

module tb_sequencer_track;

    localparam int STEPS     = 6;
    localparam int NOTE_W    = 4;
    localparam int NUM_NOTES = 13;
    localparam int GATE_W    = 4;
    localparam int STEP_W    = 3;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              sequencer_on;
    logic              toggle;
    logic [STEP_W-1:0] edit_step;
    logic              clear;
    logic [STEP_W-1:0] beat;
    logic              beat_strobe;
    logic [GATE_W-1:0] gate_len;
    logic [NOTE_W-1:0] note_out;
    logic              gate;
    logic [NOTE_W-1:0] edit_note;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        eg;
        logic [3:0]  en;
        logic        ce;
        logic [3:0]  ee;
    } exp_t;

    exp_t  sb[$];
    string nm_q[$];
    exp_t  mon_e;
    string mon_nm;

    sequencer_track #(
        .STEPS(STEPS),
        .NOTE_W(NOTE_W),
        .NUM_NOTES(NUM_NOTES),
        .GATE_W(GATE_W)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .sequencer_on(sequencer_on),
        .toggle(toggle),
        .edit_step(edit_step),
        .clear(clear),
        .beat(beat),
        .beat_strobe(beat_strobe),
        .gate_len(gate_len),
        .note_out(note_out),
        .gate(gate),
        .edit_note(edit_note)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e  = sb.pop_front();
            mon_nm = nm_q.pop_front();
            chk1({mon_nm, " gate"}, 8'(gate), 8'(mon_e.eg));
            chk1({mon_nm, " note_out"}, 8'(note_out), 8'(mon_e.en));
            if (mon_e.ce) begin
                chk1({mon_nm, " edit_note"}, 8'(edit_note), 8'(mon_e.ee));
            end
        end
    end

    task automatic tick(input logic eg, input logic [3:0] en, input logic ce,
                        input logic [3:0] ee, input string nm);
        exp_t e;
        e.eg = eg;
        e.en = en;
        e.ce = ce;
        e.ee = ee;
        sb.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #3;
        toggle      = 1'b0;
        clear       = 1'b0;
        beat_strobe = 1'b0;
    endtask

    task automatic tog(input logic [2:0] s, input logic [3:0] ee, input string nm);
        edit_step = s;
        toggle    = 1'b1;
        tick(1'b0, 4'd0, 1'b1, ee, nm);
    endtask

    task automatic strb(input logic [2:0] b, input logic eg, input logic [3:0] en, input string nm);
        beat        = b;
        beat_strobe = 1'b1;
        tick(eg, en, 1'b0, 4'd0, nm);
    endtask

    task automatic idl(input logic eg, input logic [3:0] en, input string nm);
        tick(eg, en, 1'b0, 4'd0, nm);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] expv [6];
        expv = '{4'd5, 4'd7, 4'd0, 4'd5, 4'd0, 4'd0};

        n_rst        = 1'b1;
        sequencer_on = 1'b0;
        toggle       = 1'b0;
        clear        = 1'b0;
        beat_strobe  = 1'b0;
        edit_step    = '0;
        beat         = '0;
        gate_len     = '0;
        #2 n_rst = 1'b0;
        @(posedge clk);
        #1;
        chk1("reset gate", 8'(gate), 8'd0);
        chk1("reset note_out", 8'(note_out), 8'd0);
        chk1("reset edit_note", 8'(edit_note), 8'd0);
        #2;
        n_rst        = 1'b1;
        sequencer_on = 1'b1;

        // Note cycling with wrap on step 2
        for (int i = 1; i <= 14; i++) begin
            tog(3'd2, 4'(i % 14), "cycle step2");
        end

        // Program step 3 = 5, step 0 = 5, step 1 = 7
        for (int i = 1; i <= 5; i++) tog(3'd3, 4'(i), "prog step3");
        for (int i = 1; i <= 5; i++) tog(3'd0, 4'(i), "prog step0");
        for (int i = 1; i <= 7; i++) tog(3'd1, 4'(i), "prog step1");

        // An out-of-range toggle must not disturb memory
        edit_step = 3'd6;
        toggle    = 1'b1;
        tick(1'b0, 4'd0, 1'b0, 4'd0, "oob toggle");
        for (int s = 0; s < 6; s++) begin
            edit_step = 3'(s);
            tick(1'b0, 4'd0, 1'b1, expv[s], "readback");
        end

        // A toggle in piano mode is ignored
        sequencer_on = 1'b0;
        tog(3'd0, 4'd5, "toggle while off");
        sequencer_on = 1'b1;
        idl(1'b0, 4'd0, "re-enable");

        // Single note, gate_len=3
        gate_len = 4'd3;
        strb(3'd3, 1'b1, 4'd5, "single n+1");
        idl(1'b1, 4'd5, "single n+2");
        idl(1'b1, 4'd5, "single n+3");
        idl(1'b0, 4'd0, "single n+4");

        // gate_len=0 behaves as a length of 1
        gate_len = 4'd0;
        strb(3'd3, 1'b1, 4'd5, "len0 n+1");
        idl(1'b0, 4'd0, "len0 n+2");

        // Retrigger with a different note: gap then fresh count
        gate_len = 4'd8;
        strb(3'd0, 1'b1, 4'd5, "retrig first");
        for (int i = 0; i < 3; i++) idl(1'b1, 4'd5, "retrig hold");
        strb(3'd1, 1'b0, 4'd7, "retrig gap");
        for (int i = 0; i < 8; i++) idl(1'b1, 4'd7, "retrig second");
        idl(1'b0, 4'd0, "retrig end");

        // Retrigger with the same note
        strb(3'd0, 1'b1, 4'd5, "same first");
        for (int i = 0; i < 3; i++) idl(1'b1, 4'd5, "same hold");
`ifdef SEQ_TRACK_TIE_EN
        strb(3'd3, 1'b1, 4'd5, "same tie");
        for (int i = 0; i < 7; i++) idl(1'b1, 4'd5, "same tie hold");
`else
        strb(3'd3, 1'b0, 4'd5, "same gap");
        for (int i = 0; i < 8; i++) idl(1'b1, 4'd5, "same second");
`endif
        idl(1'b0, 4'd0, "same end");

        // A strobe during the gap replaces the pending note
        gate_len = 4'd2;
        strb(3'd0, 1'b1, 4'd5, "gaprep launch");
        strb(3'd1, 1'b0, 4'd7, "gaprep gap");
        strb(3'd3, 1'b1, 4'd5, "gaprep replaced");
        idl(1'b1, 4'd5, "gaprep hold");
        idl(1'b0, 4'd0, "gaprep end");

        // A strobe on the terminal-count cycle still takes the gap
        gate_len = 4'd1;
        strb(3'd1, 1'b1, 4'd7, "tc launch");
        strb(3'd0, 1'b0, 4'd5, "tc gap");
        idl(1'b1, 4'd5, "tc second");
        idl(1'b0, 4'd0, "tc end");

        // A rest while ON silences the next cycle
        gate_len = 4'd8;
        strb(3'd1, 1'b1, 4'd7, "rest launch");
        idl(1'b1, 4'd7, "rest hold");
        strb(3'd2, 1'b0, 4'd0, "rest strobe");
        idl(1'b0, 4'd0, "rest after");

        // An out-of-range beat reads as a rest
        strb(3'd1, 1'b1, 4'd7, "oob launch");
        strb(3'd7, 1'b0, 4'd0, "oob beat");
        idl(1'b0, 4'd0, "oob after");

        // Piano mode mid-gate, memory retained, silent until the next strobe
        gate_len = 4'd2;
        strb(3'd0, 1'b1, 4'd5, "off launch");
        sequencer_on = 1'b0;
        idl(1'b0, 4'd0, "off drop");
        edit_step   = 3'd1;
        beat        = 3'd0;
        beat_strobe = 1'b1;
        tick(1'b0, 4'd0, 1'b1, 4'd7, "off strobe ignored");
        sequencer_on = 1'b1;
        idl(1'b0, 4'd0, "on no note");
        idl(1'b0, 4'd0, "on still silent");
        strb(3'd0, 1'b1, 4'd5, "on relaunch");
        idl(1'b1, 4'd5, "on hold");
        idl(1'b0, 4'd0, "on end");

        // Toggle on the playing step: old note plays, new value stored.
        // gate_len changes after launch do not affect the current note.
        gate_len    = 4'd2;
        edit_step   = 3'd3;
        toggle      = 1'b1;
        beat        = 3'd3;
        beat_strobe = 1'b1;
        tick(1'b1, 4'd5, 1'b1, 4'd6, "collide launch");
        gate_len = 4'd8;
        idl(1'b1, 4'd5, "collide hold");
        tick(1'b0, 4'd0, 1'b1, 4'd6, "collide end");

        // clear wins over toggle
        edit_step = 3'd3;
        clear     = 1'b1;
        toggle    = 1'b1;
        tick(1'b0, 4'd0, 1'b1, 4'd0, "clear+toggle");
        edit_step = 3'd0;
        tick(1'b0, 4'd0, 1'b1, 4'd0, "clear step0");
        edit_step = 3'd1;
        tick(1'b0, 4'd0, 1'b1, 4'd0, "clear step1");

        // Asynchronous reset mid-gate
        tog(3'd0, 4'd1, "prog step0 again");
        gate_len = 4'd8;
        strb(3'd0, 1'b1, 4'd1, "prereset launch");
        idl(1'b1, 4'd1, "prereset hold");
        n_rst = 1'b0;
        #1;
        chk1("async reset gate", 8'(gate), 8'd0);
        chk1("async reset note_out", 8'(note_out), 8'd0);
        @(posedge clk);
        #3;
        n_rst     = 1'b1;
        edit_step = 3'd0;
        tick(1'b0, 4'd0, 1'b1, 4'd0, "postreset");

        @(posedge clk);
        #2;
        chk1("scoreboard drained", 8'(sb.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
